fei4_cmd_seq: RTL and testbench

//  Bus-mapped FE-I4 command sequencer of the MultiIO readout FPGA. Host loads a bit pattern

---
 rtl/cmd_seq_pkg.sv | 20 ++
 rtl/cmd_seq_mem.sv | 31 +++
 rtl/fei4_cmd_seq.sv | 205 ++++++++++++++++++++
 tb/tb_fei4_cmd_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_seq_pkg.sv
// Shared definitions for the FE-I4 command sequencer: register offsets,
// version code and the serialiser state encoding.
package cmd_seq_pkg;

  localparam logic [3:0] OFF_RESET  = 4'd0;
  localparam logic [3:0] OFF_START  = 4'd1;
  localparam logic [3:0] OFF_EXT    = 4'd2;
  localparam logic [3:0] OFF_SIZE_L = 4'd3;
  localparam logic [3:0] OFF_SIZE_H = 4'd4;
  localparam logic [3:0] OFF_REP_L  = 4'd5;
  localparam logic [3:0] OFF_REP_H  = 4'd6;

  // Pattern memory starts right after the 16-byte register window.
  localparam int OFF_MEM = 16;

  localparam logic [7:0] VERSION = 8'd1;

  typedef enum logic {IDLE, SEND} state_t;

endpackage

// File: rtl/cmd_seq_mem.sv
// Pattern RAM for the command sequencer. One bus port (read/write) and one
// serialiser read port; both reads are registered, so the serialiser
// presents the address of the byte it needs on the following cycle.
module cmd_seq_mem #(
  parameter int MEM_BYTES = 2048,
  parameter int AW        = $clog2(MEM_BYTES)
) (
  input  logic          BUS_CLK,
  input  logic          bus_we,
  input  logic          bus_re,
  input  logic [AW-1:0] bus_addr,
  input  logic [7:0]    bus_wdata,
  output logic [7:0]    bus_rdata,
  input  logic [AW-1:0] ser_addr,
  output logic [7:0]    ser_rdata
);

  logic [7:0] mem [MEM_BYTES];

  // Bus port: write, and registered read held until the next read strobe.
  always_ff @(posedge BUS_CLK) begin
    if (bus_we) mem[bus_addr] <= bus_wdata;
    if (bus_re) bus_rdata <= mem[bus_addr];
  end

  // Serialiser port: free-running registered read of the prefetch address.
  always_ff @(posedge BUS_CLK) begin
    ser_rdata <= mem[ser_addr];
  end

endmodule

// File: rtl/fei4_cmd_seq.sv
// FE-I4 command sequencer: bus-mapped registers plus pattern memory,
// serialised MSB-first onto CMD_DATA one bit per BUS_CLK.
// Optional feature macro: CMD_SEQ_EXT_START_EN (external start trigger).
// Bus handshake: BUS_WR/BUS_RD are single-cycle strobes with no back-pressure;
// a write takes effect on the clock edge that samples BUS_WR, read data
// appears on BUS_DATA_OUT the cycle after BUS_RD and holds until the next read.
module fei4_cmd_seq
  import cmd_seq_pkg::*;
#(
  parameter int                   ABUSWIDTH = 16,
  parameter logic [ABUSWIDTH-1:0] BASEADDR  = 16'h0000,
  parameter logic [ABUSWIDTH-1:0] HIGHADDR  = 16'h7FFF,
  parameter int                   MEM_BYTES = 2048
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  input  logic [7:0]           BUS_DATA_IN,
  output logic [7:0]           BUS_DATA_OUT,
  input  logic                 BUS_RD,
  input  logic                 BUS_WR,
  input  logic                 EXT_START,
  output logic                 CMD_DATA,
  output logic                 READY
);

  localparam int                   AW       = $clog2(MEM_BYTES);
  localparam logic [15:0]          MAX_BITS = 16'(MEM_BYTES * 8);
  localparam logic [ABUSWIDTH-1:0] SPAN     = HIGHADDR - BASEADDR;

  logic [ABUSWIDTH:0]   off_ext;
  logic [ABUSWIDTH-1:0] off, mem_off;
  logic in_range, reg_hit, mem_hit;
  logic wr_reg, soft_rst, start_wr, ext_start, start_req, go;
  logic [15:0] size_q, rep_q, size_eff;
  logic en_ext_q;
  state_t state_q, state_d;
  logic [15:0] bit_cnt_q, bit_cnt_d, rep_cnt_q, rep_cnt_d;
  logic [15:0] act_size_q, act_size_d, act_rep_q, act_rep_d;
  logic last_bit, last_rep;
  logic [AW-1:0] ser_addr;
  logic [7:0] ser_rdata, mem_rdata, reg_rd_val, reg_rdata_q;
  logic rd_mem_q;

  // Address decode; the extra bit of off_ext flags addresses below BASEADDR.
  assign off_ext  = {1'b0, BUS_ADD} - {1'b0, BASEADDR};
  assign off      = off_ext[ABUSWIDTH-1:0];
  assign in_range = !off_ext[ABUSWIDTH] && (off <= SPAN);
  assign reg_hit  = in_range && (off[ABUSWIDTH-1:4] == '0);
  assign mem_off  = off - ABUSWIDTH'(OFF_MEM);
  assign mem_hit  = in_range && !reg_hit && (mem_off < ABUSWIDTH'(MEM_BYTES));

  assign wr_reg   = BUS_WR && reg_hit;
  assign soft_rst = wr_reg && (off[3:0] == OFF_RESET);
  assign start_wr = wr_reg && (off[3:0] == OFF_START);

`ifdef CMD_SEQ_EXT_START_EN
  logic [2:0] ext_sync_q;

  // Two-flop synchroniser plus one history flop for rising-edge detection.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) ext_sync_q <= 3'b000;
    else         ext_sync_q <= {ext_sync_q[1:0], EXT_START};
  end

  // External-start enable bit, cleared by soft reset like the other registers.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST)                                 en_ext_q <= 1'b0;
    else if (soft_rst)                           en_ext_q <= 1'b0;
    else if (wr_reg && (off[3:0] == OFF_EXT))    en_ext_q <= BUS_DATA_IN[0];
  end

  assign ext_start = en_ext_q && ext_sync_q[1] && !ext_sync_q[2];
`else
  logic unused_ext_start;
  assign unused_ext_start = EXT_START;
  assign en_ext_q         = 1'b0;
  assign ext_start        = 1'b0;
`endif

  // Configuration registers; soft reset clears them ahead of any write.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      size_q <= '0;
      rep_q  <= '0;
    end else if (soft_rst) begin
      size_q <= '0;
      rep_q  <= '0;
    end else if (wr_reg) begin
      case (off[3:0])
        OFF_SIZE_L: size_q[7:0]  <= BUS_DATA_IN;
        OFF_SIZE_H: size_q[15:8] <= BUS_DATA_IN;
        OFF_REP_L:  rep_q[7:0]   <= BUS_DATA_IN;
        OFF_REP_H:  rep_q[15:8]  <= BUS_DATA_IN;
        default:    ;
      endcase
    end
  end

  assign size_eff  = (size_q > MAX_BITS) ? MAX_BITS : size_q;
  assign start_req = start_wr || ext_start;
  assign go        = start_req && (state_q == IDLE) && (size_eff != 16'd0) && !soft_rst;

  // Sequencer state and counters; SIZE/REPEAT are snapshotted at start so
  // register writes during a sequence only affect the next one.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rep_cnt_q  <= '0;
      act_size_q <= '0;
      act_rep_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      act_size_q <= act_size_d;
      act_rep_q  <= act_rep_d;
    end
  end

  assign last_bit = (bit_cnt_q == act_size_q - 16'd1);
  assign last_rep = (rep_cnt_q == act_rep_q - 16'd1);

  // Next-state logic; the next bit index also drives the memory prefetch.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    act_size_d = act_size_q;
    act_rep_d  = act_rep_q;
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        rep_cnt_d = '0;
        if (go) begin
          state_d    = SEND;
          act_size_d = size_eff;
          act_rep_d  = (rep_q == 16'd0) ? 16'd1 : rep_q;
        end
      end
      SEND: begin
        if (last_bit) begin
          bit_cnt_d = '0;
          if (last_rep) state_d = IDLE;
          else          rep_cnt_d = rep_cnt_q + 16'd1;
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (soft_rst) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      rep_cnt_d = '0;
    end
  end

  assign ser_addr = bit_cnt_d[AW+2:3];

  // CMD_DATA is a mux of registered signals only, forced low outside SEND.
  assign CMD_DATA = (state_q == SEND) && ser_rdata[~bit_cnt_q[2:0]];
  assign READY    = (state_q == IDLE);

  // Register read mux.
  always_comb begin
    reg_rd_val = 8'h00;
    case (off[3:0])
      OFF_RESET:  reg_rd_val = VERSION;
      OFF_START:  reg_rd_val = {7'b0, READY};
      OFF_EXT:    reg_rd_val = {7'b0, en_ext_q};
      OFF_SIZE_L: reg_rd_val = size_q[7:0];
      OFF_SIZE_H: reg_rd_val = size_q[15:8];
      OFF_REP_L:  reg_rd_val = rep_q[7:0];
      OFF_REP_H:  reg_rd_val = rep_q[15:8];
      default:    reg_rd_val = 8'h00;
    endcase
  end

  // Read data capture; remembers whether the last read targeted memory.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      rd_mem_q    <= 1'b0;
      reg_rdata_q <= 8'h00;
    end else if (BUS_RD) begin
      rd_mem_q    <= mem_hit;
      reg_rdata_q <= reg_hit ? reg_rd_val : 8'h00;
    end
  end

  assign BUS_DATA_OUT = rd_mem_q ? mem_rdata : reg_rdata_q;

  cmd_seq_mem #(.MEM_BYTES(MEM_BYTES), .AW(AW)) u_mem (
    .BUS_CLK   (BUS_CLK),
    .bus_we    (BUS_WR && mem_hit),
    .bus_re    (BUS_RD && mem_hit),
    .bus_addr  (mem_off[AW-1:0]),
    .bus_wdata (BUS_DATA_IN),
    .bus_rdata (mem_rdata),
    .ser_addr  (ser_addr),
    .ser_rdata (ser_rdata)
  );

endmodule

// File: tb/tb_fei4_cmd_seq.sv
// Self-checking bench for fei4_cmd_seq: directed FE-I4 command patterns,
// randomized patterns/lengths/repeats, aborts, clamping and external start.
module tb_fei4_cmd_seq;

  localparam int MEM_BYTES = 2048;
  localparam int MAX_BITS  = MEM_BYTES * 8;

  logic        BUS_CLK = 1'b0;
  logic        BUS_RST = 1'b1;
  logic [15:0] BUS_ADD = '0;
  logic [7:0]  BUS_DATA_IN = '0;
  logic [7:0]  BUS_DATA_OUT;
  logic        BUS_RD = 1'b0;
  logic        BUS_WR = 1'b0;
  logic        EXT_START = 1'b0;
  logic        CMD_DATA;
  logic        READY;

  // Clock
  always #5 BUS_CLK = ~BUS_CLK;

  fei4_cmd_seq dut (
    .BUS_CLK      (BUS_CLK),
    .BUS_RST      (BUS_RST),
    .BUS_ADD      (BUS_ADD),
    .BUS_DATA_IN  (BUS_DATA_IN),
    .BUS_DATA_OUT (BUS_DATA_OUT),
    .BUS_RD       (BUS_RD),
    .BUS_WR       (BUS_WR),
    .EXT_START    (EXT_START),
    .CMD_DATA     (CMD_DATA),
    .READY        (READY)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0]  m_mem [MEM_BYTES];
  logic [15:0] m_size = '0;
  logic [15:0] m_rep  = '0;
  logic        m_en   = 1'b0;
  logic [0:0]  exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Model effect of a bus write
  function automatic void model_write(input logic [15:0] a, input logic [7:0] d);
    if (a == 16'd0) begin
      m_size = '0;
      m_rep  = '0;
      m_en   = 1'b0;
    end else if (a == 16'd2) begin
`ifdef CMD_SEQ_EXT_START_EN
      m_en = d[0];
`endif
    end else if (a == 16'd3) m_size[7:0]  = d;
    else if (a == 16'd4)     m_size[15:8] = d;
    else if (a == 16'd5)     m_rep[7:0]   = d;
    else if (a == 16'd6)     m_rep[15:8]  = d;
    else if (a >= 16'd16 && a < 16'(16 + MEM_BYTES)) m_mem[a - 16'd16] = d;
  endfunction

  // Expected stream: clamped SIZE bits from memory, MSB first, REPEAT times
  function automatic void build_exp();
    int sz, reps;
    exp_q.delete();
    sz   = (int'(m_size) > MAX_BITS) ? MAX_BITS : int'(m_size);
    reps = (m_rep == 16'd0) ? 1 : int'(m_rep);
    for (int r = 0; r < reps; r++)
      for (int k = 0; k < sz; k++)
        exp_q.push_back(m_mem[k / 8][7 - (k % 8)]);
  endfunction

  // Driver tasks
  task automatic reg_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge BUS_CLK);
    BUS_ADD = a; BUS_DATA_IN = d; BUS_WR = 1'b1;
    model_write(a, d);
    @(negedge BUS_CLK);
    BUS_WR = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge BUS_CLK);
    BUS_ADD = a; BUS_RD = 1'b1;
    @(negedge BUS_CLK);
    BUS_RD = 1'b0;
    d = BUS_DATA_OUT;
  endtask

  task automatic set_cfg(input logic [15:0] size, input logic [15:0] rep);
    reg_write(16'd3, size[7:0]);
    reg_write(16'd4, size[15:8]);
    reg_write(16'd5, rep[7:0]);
    reg_write(16'd6, rep[15:8]);
  endtask

  // Checks exp_q from the current negedge; optionally injects one bus write
  // after bit inj_at has been checked.
  task automatic check_stream(input string tag, input int inj_at,
                              input logic [15:0] a, input logic [7:0] d);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s bit%0d", tag, i), {31'b0, CMD_DATA}, {31'b0, exp_q[i]});
      check_eq($sformatf("%s busy%0d", tag, i), {31'b0, READY}, 32'd0);
      if (i == inj_at) begin
        BUS_ADD = a; BUS_DATA_IN = d; BUS_WR = 1'b1;
        model_write(a, d);
      end
      @(negedge BUS_CLK);
      BUS_WR = 1'b0;
      if (i == inj_at && a == 16'd0) break;
    end
    check_eq({tag, " ready_after"}, {31'b0, READY}, 32'd1);
    check_eq({tag, " cmd_idle"}, {31'b0, CMD_DATA}, 32'd0);
  endtask

  task automatic start_and_check(input string tag, input int inj_at,
                                 input logic [15:0] a, input logic [7:0] d);
    build_exp();
    reg_write(16'd1, 8'h00);
    if (exp_q.size() == 0) begin
      for (int c = 0; c < 3; c++) begin
        check_eq({tag, " stays_ready"}, {31'b0, READY}, 32'd1);
        check_eq({tag, " cmd_low"}, {31'b0, CMD_DATA}, 32'd0);
        @(negedge BUS_CLK);
      end
    end else begin
      check_stream(tag, inj_at, a, d);
    end
  endtask

  // External trigger pulse; the model decides whether a sequence must follow.
  task automatic ext_pulse_check(input string tag);
    bit found;
    build_exp();
    if (!m_en) exp_q.delete();
    @(negedge BUS_CLK);
    EXT_START = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      @(negedge BUS_CLK);
      if (c == 1) EXT_START = 1'b0;
      if (READY == 1'b0) found = 1'b1;
    end
    EXT_START = 1'b0;
    check_eq({tag, " started"}, {31'b0, found}, {31'b0, exp_q.size() != 0});
    if (found) check_stream(tag, -1, 16'd0, 8'd0);
  endtask

  logic [7:0] rd;

  initial begin
    // Reset
    repeat (3) @(negedge BUS_CLK);
    check_eq("rst ready", {31'b0, READY}, 32'd1);
    check_eq("rst cmd", {31'b0, CMD_DATA}, 32'd0);
    check_eq("rst dout", {24'b0, BUS_DATA_OUT}, 32'd0);
    BUS_RST = 1'b0;

    bus_read(16'd0, rd);      check_eq("version", {24'b0, rd}, 32'd1);
    bus_read(16'd1, rd);      check_eq("ready_reg", {24'b0, rd}, 32'd1);
    bus_read(16'd3, rd);      check_eq("size_rst", {24'b0, rd}, 32'd0);
    bus_read(16'd5, rd);      check_eq("rep_rst", {24'b0, rd}, 32'd0);
    reg_write(16'd9, 8'h5A);
    bus_read(16'd9, rd);      check_eq("unmapped", {24'b0, rd}, 32'd0);
    bus_read(16'h8000, rd);   check_eq("out_of_range", {24'b0, rd}, 32'd0);

    // Fill whole pattern memory with random data
    for (int i = 0; i < MEM_BYTES; i++) reg_write(16'(16 + i), 8'($urandom));
    for (int i = 0; i < 4; i++) begin
      int k;
      k = $urandom_range(0, MEM_BYTES - 1);
      bus_read(16'(16 + k), rd);
      check_eq($sformatf("mem_rb%0d", k), {24'b0, rd}, {24'b0, m_mem[k]});
    end

    // ECR
    reg_write(16'd16, 8'hB1); reg_write(16'd17, 8'h00);
    set_cfg(16'd9, 16'd0);
    start_and_check("ecr", -1, 16'd0, 8'd0);

    // LV1
    reg_write(16'd16, 8'hE8);
    set_cfg(16'd5, 16'd0);
    start_and_check("lv1", -1, 16'd0, 8'd0);

    // Repeat, back-to-back
    reg_write(16'd16, 8'h81); reg_write(16'd17, 8'h7E); reg_write(16'd18, 8'hA1);
    set_cfg(16'd11, 16'd3);
    bus_read(16'd5, rd);      check_eq("rep_readback", {24'b0, rd}, {24'b0, m_rep[7:0]});
    start_and_check("repeat", -1, 16'd0, 8'd0);

    // Randomized patterns
    for (int t = 0; t < 8; t++) begin
      for (int b = 0; b < 12; b++) reg_write(16'(16 + b), 8'($urandom));
      set_cfg(16'($urandom_range(1, 90)), 16'($urandom_range(0, 3)));
      start_and_check($sformatf("rand%0d", t), -1, 16'd0, 8'd0);
    end

    // Start during SEND is ignored
    set_cfg(16'd16, 16'd1);
    start_and_check("restart", 4, 16'd1, 8'd0);

    // SIZE write during SEND only affects the next start
    start_and_check("size_mid", 3, 16'd3, 8'd4);
    start_and_check("size_next", -1, 16'd0, 8'd0);

    // Soft reset mid-sequence
    set_cfg(16'd16, 16'd2);
    start_and_check("abort", 3, 16'd0, 8'd0);
    bus_read(16'd3, rd);      check_eq("abort_size", {24'b0, rd}, {24'b0, m_size[7:0]});
    bus_read(16'd5, rd);      check_eq("abort_rep", {24'b0, rd}, {24'b0, m_rep[7:0]});

    // SIZE=0 start ignored
    start_and_check("size0", -1, 16'd0, 8'd0);

    // SIZE larger than memory clamps to the full memory
    set_cfg(16'h4005, 16'd1);
    start_and_check("clamp", -1, 16'd0, 8'd0);

    // External start
    reg_write(16'd16, 8'hE8);
    set_cfg(16'd5, 16'd0);
    reg_write(16'd2, 8'h01);
    bus_read(16'd2, rd);      check_eq("ext_en_rb", {24'b0, rd}, {31'b0, m_en});
    ext_pulse_check("ext_on");
    reg_write(16'd2, 8'h00);
    ext_pulse_check("ext_off");

    // Hardware reset mid-sequence
    set_cfg(16'd20, 16'd0);
    build_exp();
    reg_write(16'd1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("hwrst bit%0d", i), {31'b0, CMD_DATA}, {31'b0, exp_q[i]});
      @(negedge BUS_CLK);
    end
    BUS_RST = 1'b1;
    model_write(16'd0, 8'd0);
    @(negedge BUS_CLK);
    check_eq("hwrst ready", {31'b0, READY}, 32'd1);
    check_eq("hwrst cmd", {31'b0, CMD_DATA}, 32'd0);
    BUS_RST = 1'b0;
    bus_read(16'd3, rd);      check_eq("hwrst_size", {24'b0, rd}, {24'b0, m_size[7:0]});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
